// File: rtl/knn_kbest.sv
// knn_kbest: keeps the K smallest (distance, label) candidates of a query in an
// ascending register list, inserting one candidate per cycle, then freezes the
// list and serves it through a zero-latency indexed read port.
module knn_kbest #(
    parameter int DATA_W  = 16,
    parameter int LABEL_W = 8,
    parameter int K       = 4,
    parameter int IDX_W   = (K > 1) ? $clog2(K) : 1,
    parameter int CNT_W   = $clog2(K + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [DATA_W-1:0]  in_dist,
    input  logic [LABEL_W-1:0] in_label,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [DATA_W-1:0]  rd_dist,
    output logic [LABEL_W-1:0] rd_label,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   count,
    output logic               done
);

    typedef enum logic {
        S_FILL,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                accept;
    logic [K-1:0]        vld_q, vld_d;
    logic [K-1:0]        le;
    logic [DATA_W-1:0]   dist_q  [K];
    logic [DATA_W-1:0]   dist_d  [K];
    logic [LABEL_W-1:0]  label_q [K];
    logic [LABEL_W-1:0]  label_d [K];
    logic [CNT_W-1:0]    count_q;

    // clear wins over a simultaneous candidate, so it never reaches the list
    assign accept = in_valid && (state_q == S_FILL) && !clear;
    assign count  = count_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FILL;
        else      state_q <= state_d;
    end

    // Next state and handshake outputs; outputs depend on state only
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_d = S_DONE;
            end
            S_DONE: done = 1'b1;
            default: state_d = S_FILL;
        endcase
        if (clear) state_d = S_FILL;
    end

    // Sorted insert: le[] is a prefix of ones because valid entries are
    // contiguous and ascending, so the first zero is the insert slot and every
    // later slot takes its upper neighbour. All ones means the candidate is
    // dropped. Using <= places ties after existing equal entries.
    always_comb begin
        vld_d   = vld_q;
        dist_d  = dist_q;
        label_d = label_q;
        le      = '0;
        for (int unsigned i = 0; i < K; i++) begin
            le[i] = vld_q[i] && (dist_q[i] <= in_dist);
        end
        if (clear) begin
            vld_d = '0;
        end else if (accept) begin
            if (!le[0]) begin
                vld_d[0]   = 1'b1;
                dist_d[0]  = in_dist;
                label_d[0] = in_label;
            end
            for (int unsigned i = 1; i < K; i++) begin
                if (!le[i]) begin
                    if (le[i-1]) begin
                        vld_d[i]   = 1'b1;
                        dist_d[i]  = in_dist;
                        label_d[i] = in_label;
                    end else begin
                        vld_d[i]   = vld_q[i-1];
                        dist_d[i]  = dist_q[i-1];
                        label_d[i] = label_q[i-1];
                    end
                end
            end
        end
    end

    // Neighbour list registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < K; i++) begin
                dist_q[i]  <= '0;
                label_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            dist_q  <= dist_d;
            label_q <= label_d;
        end
    end

    // Valid-entry count, saturating at K
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (accept && (count_q != CNT_W'(K))) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Read port: invalid or out-of-range entries read as zero
    always_comb begin
        rd_valid = 1'b0;
        rd_dist  = '0;
        rd_label = '0;
        for (int unsigned i = 0; i < K; i++) begin
            if ((rd_idx == IDX_W'(i)) && vld_q[i]) begin
                rd_valid = 1'b1;
                rd_dist  = dist_q[i];
                rd_label = label_q[i];
            end
        end
    end

endmodule

// File: doc/knn_kbest.md
# knn_kbest

Downstream stage of the KNN distance core: it consumes one (distance, label) candidate per cycle and keeps the K smallest distances in ascending order. Each candidate is inserted into a sorted register list in a single cycle, and larger entries shift down. Once the last candidate of a query is accepted, the block freezes and exposes the sorted neighbours through an indexed read port. A classifier or the CPU-facing register bank reads the result from that port.

## Interface
- DATA_W, 16: distance width (unsigned), matches knn_core output.
- LABEL_W, 8: class label width.
- K, 4: number of neighbours kept; K ≥ 1.
- IDX_W, $clog2(K) (min 1): read index width.
- CNT_W, $clog2(K+1): count width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous clear of list and state.
- in_valid  input  1  candidate present.
- in_ready  output  1  block accepts a candidate this cycle.
- in_last  input  1  candidate is the final one of the query.
- in_dist  input  DATA_W  candidate distance.
- in_label  input  LABEL_W  candidate label.
- rd_idx  input  IDX_W  entry to read; 0 is nearest.
- rd_dist  output  DATA_W  distance of entry rd_idx.
- rd_label  output  LABEL_W  label of entry rd_idx.
- rd_valid  output  1  entry rd_idx holds data.
- count  output  CNT_W  number of valid entries, saturates at K.
- done  output  1  query complete, list frozen.

## Operation
- Storage: K entries, each holding {valid, dist, label}. Entry 0 is the smallest distance. Valid entries are contiguous from index 0.
- States:
  - FILL (reset state): in_ready=1.
  - DONE: in_ready=0, done=1.
- Accept: a candidate is accepted when in_valid && in_ready.
- Insert position p: the number of valid entries with dist ≤ in_dist. Comparison is unsigned. Invalid entries compare greater than any distance.
- Ties: equal distances insert after existing equal entries, so the earlier candidate ranks nearer.
- If p < K: entries p..K-2 shift to p+1..K-1, the old entry K-1 is discarded, and the candidate is written to p with valid=1.
- If p == K: the list is unchanged. The candidate is still accepted and counts toward in_last.
- count increments on each insert while count < K, then holds at K.
- FILL → DONE: on an accepted candidate with in_last=1. That candidate is inserted normally first.
- DONE → FILL: only on clear.
- clear, in any state: all valid bits=0, count=0, state=FILL. The dist and label fields need not be zeroed.
- clear has priority over a simultaneous accept. The candidate is dropped, including any in_last.
- rd_idx ≥ K: rd_valid=0, rd_dist=0, rd_label=0.
- For an invalid entry, rd_dist and rd_label read 0.
- Read port is usable in any state. Reads during FILL return the partial list.

## Timing
- Reset (rst=0, asynchronous): all entries invalid, count=0, done=0, state=FILL. in_ready becomes 1 immediately. rd_valid=0, rd_dist=0, rd_label=0 for every rd_idx.
- Reset asserted mid-query discards all entries at once. There is no partial recovery.
- Throughput: one candidate per cycle, with no bubbles between consecutive candidates.
- Latency: an accepted candidate is visible on the read port and in count in the cycle after the accepting edge.
- done and in_ready=0 appear the cycle after the edge that accepts in_last.
- in_ready and done are pure functions of state, with no combinational path from in_valid.
- rd_* are combinational from rd_idx and the registered list (zero-cycle read).
- clear takes effect at the next edge. in_ready is 1 in the following cycle.
- Inputs change only on the ready/valid handshake; in_dist, in_label and in_last are sampled only on accept.

## Test plan
All scenarios use K=4 and DATA_W=16.
- Fill and sort: after reset, send dist 50,20,70,10 with labels 1,2,3,4 on consecutive cycles, in_last=0 → entries 0..3 = 10/4, 20/2, 50/1, 70/3; count=4; done=0.
- Eviction: continue with 30/5 → list becomes 10/4, 20/2, 30/5, 50/1. Then send 90/6 → list unchanged, count=4.
- Tie: continue with 20/7 → list becomes 10/4, 20/2, 20/7, 30/5.
- Last and freeze: send 5/8 with in_last=1 → next cycle the list is 5/8, 10/4, 20/2, 20/7, done=1, in_ready=0. Hold in_valid=1 with 1/9 for 3 cycles → list unchanged. Then pulse clear → next cycle count=0, done=0, in_ready=1, all rd_valid=0.
- Boundaries: on an empty list, send 0xFFFF/3 → entry 0 = 0xFFFF/3, count=1. Assert clear together with a valid candidate 7/1 carrying in_last=1 → list empty, done=0. Read rd_idx=0 → rd_valid=0 and rd_dist=0; separately, any rd_idx ≥ 4 reads valid=0.
- Async reset: send two candidates, then drop rst between clock edges → count=0, done=0, and rd_valid=0 for every rd_idx before the next edge. After release, 40/2 → entry 0 = 40/2, count=1.
